conv1_window_ctrl: RTL and testbench

- Sequences 3x3 (KxK) window reads from the conv1 line/window buffer for one feature-map plane stored row-major.
- Tracks how many pixels the producer has written and issues a window read only once every pixel of that window is resident.
- Generates the window base address and output coordinates, skips invalid edge positions and applies stride.
- Sits between the buffer's write side (pixel producer), its read side (rd_en/rd_addr) and the downstream conv1 MAC array (valid/ready).

---
 rtl/conv1_window_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_conv1_window_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv1_window_ctrl
//  Description : Read sequencer for the conv1 line/window buffer. Tracks how
//                many pixels of a row-major plane the producer has written,
//                issues a KxK window read once every pixel of that window is
//                resident, and presents window coordinates to the MAC array
//                through a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv1_window_ctrl #(
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 224,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int OUT_W  = (IMG_W - K) / STRIDE + 1,
    parameter int OUT_H  = (IMG_H - K) / STRIDE + 1,
    parameter int AW     = $clog2(IMG_W * IMG_H + 1),
    localparam int c_row_w = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int c_col_w = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic               clk,
    input  logic               rst_a,
    input  logic               start,
    input  logic               wr_fire,
    input  logic               win_ready,
    output logic               rd_en,
    output logic [AW-1:0]      rd_addr,
    output logic               win_valid,
    output logic [c_row_w-1:0] out_row,
    output logic [c_col_w-1:0] out_col,
    output logic               busy,
    output logic               done,
    output logic               ovf_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_aw1 = AW + 1;

    // Total pixels in a plane; wr_count saturates here.
    localparam logic [AW-1:0] c_npix = AW'(IMG_W * IMG_H);

    // Offset from a window's top-left pixel to its bottom-right pixel. The
    // window is complete once the producer has written past that pixel.
    localparam logic [AW:0] c_span = c_aw1'((K - 1) * IMG_W + (K - 1));

    // Base-address increments: one stride right, or wrap to the start of the
    // next output row (stride rows down, back to column 0).
    localparam logic [AW-1:0] c_col_step = AW'(STRIDE);
    localparam logic [AW-1:0] c_row_step = AW'(STRIDE * IMG_W - (OUT_W - 1) * STRIDE);

    localparam logic [c_col_w-1:0] c_last_col = c_col_w'(OUT_W - 1);
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(OUT_H - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [AW-1:0]        r_wr_count;
    logic                 r_ovf_err;
    logic [c_row_w-1:0]   r_row;        // coordinates of the next read to issue
    logic [c_col_w-1:0]   r_col;
    logic [AW-1:0]        r_base;       // top-left address of the next read
    logic                 r_win_valid;
    logic [c_row_w-1:0]   r_out_row;    // coordinates of the presented window
    logic [c_col_w-1:0]   r_out_col;
    logic                 r_done;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [AW:0] w_need;
    logic        w_win_avail;
    logic        w_slot_free;
    logic        w_rd_en;
    logic        w_last_pos;
    logic        w_accept;

    // Highest pixel address the next window touches; one extra bit keeps the
    // sum exact for the bottom-right window of the plane.
    assign w_need      = {1'b0, r_base} + c_span;

    // Registered count only: a pixel written this cycle is visible next cycle.
    assign w_win_avail = ({1'b0, r_wr_count} > w_need);

    // The output register can take a new window if it is empty or the
    // current one retires on this same edge.
    assign w_slot_free = !r_win_valid || win_ready;
    assign w_accept    = r_win_valid && win_ready;

    assign w_rd_en     = (r_state == S_RUN) && w_win_avail && w_slot_free;
    assign w_last_pos  = (r_row == c_last_row) && (r_col == c_last_col);

    // ------------------------------------------------------------------------
    // Control FSM, coordinate/base-address walk and window presentation
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_base      <= '0;
            r_win_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Buffer data_out is registered, so the window becomes valid the
            // cycle after its read; a read and a retire together keep valid high.
            if (w_rd_en) begin
                r_win_valid <= 1'b1;
                r_out_row   <= r_row;
                r_out_col   <= r_col;
            end else if (w_accept) begin
                r_win_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_base  <= '0;
                    end
                end

                S_RUN: begin
                    if (w_rd_en) begin
                        // Only valid positions are walked, so the K-1 edge
                        // columns and rows never generate a read.
                        if (r_col == c_last_col) begin
                            r_col  <= '0;
                            r_row  <= r_row + 1'b1;
                            r_base <= r_base + c_row_step;
                        end else begin
                            r_col  <= r_col + 1'b1;
                            r_base <= r_base + c_col_step;
                        end
                        if (w_last_pos) begin
                            r_state <= S_LAST;
                        end
                    end
                end

                S_LAST: begin
                    // The final window is already in the output register.
                    if (w_accept) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Producer pixel counter with sticky overflow flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_wr_count <= '0;
            r_ovf_err  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            // The start cycle already belongs to the new plane.
            if (start) begin
                r_wr_count <= AW'(wr_fire);
            end
        end else if (wr_fire) begin
            if (r_wr_count == c_npix) begin
                r_ovf_err <= 1'b1;
            end else begin
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rd_en     = w_rd_en;
    assign rd_addr   = w_rd_en ? r_base : '0;
    assign win_valid = r_win_valid;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign ovf_err   = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_conv1_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv1_window_ctrl
//  Description : Self-checking bench for conv1_window_ctrl. Instance A runs a
//                5x4 plane (stride 1), instance B a 7x7 plane (stride 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv1_window_ctrl;

    localparam int A_W = 5, A_H = 4, A_S = 1, A_OW = 3, A_OH = 2, A_NPIX = 20;
    localparam int B_W = 7, B_H = 7, B_S = 2, B_OW = 3, B_OH = 3, B_NPIX = 49;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic       a_rst_a, a_start, a_wr, a_rdy;
    logic       a_rd_en, a_win_valid, a_busy, a_done, a_ovf;
    logic [4:0] a_rd_addr;
    logic [0:0] a_out_row;
    logic [1:0] a_out_col;

    // Instance B
    logic       b_rst_a, b_start, b_wr, b_rdy;
    logic       b_rd_en, b_win_valid, b_busy, b_done, b_ovf;
    logic [5:0] b_rd_addr;
    logic [1:0] b_out_row;
    logic [1:0] b_out_col;

    conv1_window_ctrl #(.IMG_W(A_W), .IMG_H(A_H), .K(3), .STRIDE(A_S)) u_dut_a (
        .clk(clk), .rst_a(a_rst_a), .start(a_start), .wr_fire(a_wr), .win_ready(a_rdy),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .win_valid(a_win_valid),
        .out_row(a_out_row), .out_col(a_out_col), .busy(a_busy), .done(a_done),
        .ovf_err(a_ovf)
    );

    conv1_window_ctrl #(.IMG_W(B_W), .IMG_H(B_H), .K(3), .STRIDE(B_S)) u_dut_b (
        .clk(clk), .rst_a(b_rst_a), .start(b_start), .wr_fire(b_wr), .win_ready(b_rdy),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .win_valid(b_win_valid),
        .out_row(b_out_row), .out_col(b_out_col), .busy(b_busy), .done(b_done),
        .ovf_err(b_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard: expected reads and presented windows, pushed at start
    // ------------------------------------------------------------------------
    typedef struct { int row; int col; } coord_t;

    int     a_addr_q[$];
    coord_t a_crd_q[$];
    int     b_addr_q[$];
    coord_t b_crd_q[$];

    int a_pix = 0, b_pix = 0;       // pixels the bench has driven this plane
    bit a_plane = 0, b_plane = 0;   // bench believes a plane is in flight
    bit b_last_seen = 0;

    int     a_e, b_e;
    coord_t a_ce, b_ce;

    // Pixels already registered by the DUT: the current cycle's write is not.
    function automatic int a_reg_cnt();
        int v;
        v = a_pix - int'(a_wr);
        return (v > A_NPIX) ? A_NPIX : v;
    endfunction

    function automatic int b_reg_cnt();
        int v;
        v = b_pix - int'(b_wr);
        return (v > B_NPIX) ? B_NPIX : v;
    endfunction

    task automatic a_cycle(input logic st, input logic wf, input logic rdy);
        @(posedge clk); #1;
        a_start = st; a_wr = wf; a_rdy = rdy;
        if (st && !a_plane) begin
            a_plane = 1'b1;
            a_pix   = int'(wf);
            for (int r = 0; r < A_OH; r++)
                for (int c = 0; c < A_OW; c++) begin
                    a_addr_q.push_back(r * A_S * A_W + c * A_S);
                    a_crd_q.push_back('{r, c});
                end
        end else if (wf && a_plane) begin
            a_pix++;
        end
        @(negedge clk); #1;
        if (a_done) a_plane = 1'b0;
    endtask

    task automatic b_cycle(input logic st, input logic wf, input logic rdy);
        @(posedge clk); #1;
        b_start = st; b_wr = wf; b_rdy = rdy;
        if (st && !b_plane) begin
            b_plane = 1'b1;
            b_pix   = int'(wf);
            for (int r = 0; r < B_OH; r++)
                for (int c = 0; c < B_OW; c++) begin
                    b_addr_q.push_back(r * B_S * B_W + c * B_S);
                    b_crd_q.push_back('{r, c});
                end
        end else if (wf && b_plane) begin
            b_pix++;
        end
        @(negedge clk); #1;
        if (b_done) b_plane = 1'b0;
    endtask

    // Run A to completion with win_ready=1, writing any missing pixels.
    task automatic a_finish(input string nm);
        int n;
        n = 0;
        while (a_plane && n < 200) begin
            a_cycle(1'b0, a_pix < A_NPIX, 1'b1);
            n++;
        end
        chk({nm, "_done_seen"}, a_plane, 0);
        chk({nm, "_reads_left"}, a_addr_q.size(), 0);
        chk({nm, "_wins_left"}, a_crd_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (a_rst_a) begin
            if (a_rd_en) begin
                if (a_addr_q.size() == 0) chk("a_rd_unexpected", a_rd_en, 0);
                else begin
                    a_e = a_addr_q.pop_front();
                    chk("a_rd_addr", a_rd_addr, a_e);
                    chk("a_rd_data_ready", a_reg_cnt() > a_e + 2 * A_W + 2, 1);
                end
            end
            if (a_win_valid && a_rdy) begin
                if (a_crd_q.size() == 0) chk("a_win_unexpected", a_win_valid, 0);
                else begin
                    a_ce = a_crd_q.pop_front();
                    chk("a_out_row", a_out_row, a_ce.row);
                    chk("a_out_col", a_out_col, a_ce.col);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_rst_a) begin
            if (b_rd_en) begin
                if (b_addr_q.size() == 0) chk("b_rd_unexpected", b_rd_en, 0);
                else begin
                    b_e = b_addr_q.pop_front();
                    chk("b_rd_addr", b_rd_addr, b_e);
                    chk("b_rd_data_ready", b_reg_cnt() > b_e + 2 * B_W + 2, 1);
                    if (b_e == 32) begin
                        b_last_seen = 1'b1;
                        chk("b_last_rd_count", b_reg_cnt(), B_NPIX);
                    end
                end
            end
            if (b_win_valid && b_rdy) begin
                if (b_crd_q.size() == 0) chk("b_win_unexpected", b_win_valid, 0);
                else begin
                    b_ce = b_crd_q.pop_front();
                    chk("b_out_row", b_out_row, b_ce.row);
                    chk("b_out_col", b_out_col, b_ce.col);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Cycle table for the streaming 5x4 plane (1 pixel/cycle, win_ready=1)
    // ------------------------------------------------------------------------
    typedef struct {
        int st; int wf; int rdy;
        int rd; int addr; int vld; int row; int col; int busy; int done;
    } vec_t;

    vec_t tv[24];

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        a_rst_a = 1'b0; a_start = 1'b0; a_wr = 1'b0; a_rdy = 1'b0;
        b_rst_a = 1'b0; b_start = 1'b0; b_wr = 1'b0; b_rdy = 1'b0;

        //           st wf rdy rd addr vld row col busy done
        tv[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 1; i <= 12; i++) tv[i] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
        tv[13] = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 0};
        tv[14] = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 0};
        tv[15] = '{0, 1, 1, 1, 2, 1, 0, 1, 1, 0};
        tv[16] = '{0, 1, 1, 0, 0, 1, 0, 2, 1, 0};
        tv[17] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
        tv[18] = '{0, 1, 1, 1, 5, 0, 0, 0, 1, 0};
        tv[19] = '{0, 1, 1, 1, 6, 1, 1, 0, 1, 0};
        tv[20] = '{0, 0, 1, 1, 7, 1, 1, 1, 1, 0};
        tv[21] = '{0, 0, 1, 0, 0, 1, 1, 2, 1, 0};
        tv[22] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        tv[23] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

        // Reset values
        #12;
        chk("rst_rd_en", a_rd_en, 0);
        chk("rst_rd_addr", a_rd_addr, 0);
        chk("rst_win_valid", a_win_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_b_busy", b_busy, 0);
        @(negedge clk);
        a_rst_a = 1'b1;
        b_rst_a = 1'b1;

        // Streaming plane, cycle by cycle
        for (int i = 0; i < 24; i++) begin
            a_cycle(tv[i].st != 0, tv[i].wf != 0, tv[i].rdy != 0);
            chk($sformatf("tbl_rd_en[%0d]", i), a_rd_en, tv[i].rd);
            if (tv[i].rd != 0) chk($sformatf("tbl_rd_addr[%0d]", i), a_rd_addr, tv[i].addr);
            chk($sformatf("tbl_win_valid[%0d]", i), a_win_valid, tv[i].vld);
            if (tv[i].vld != 0) begin
                chk($sformatf("tbl_out_row[%0d]", i), a_out_row, tv[i].row);
                chk($sformatf("tbl_out_col[%0d]", i), a_out_col, tv[i].col);
            end
            chk($sformatf("tbl_busy[%0d]", i), a_busy, tv[i].busy);
            chk($sformatf("tbl_done[%0d]", i), a_done, tv[i].done);
        end
        chk("tbl_reads_left", a_addr_q.size(), 0);

        // Backpressure: all pixels written, first window held
        a_cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) a_cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a_cycle(1'b0, 1'b0, 1'b0);
            chk("hold_win_valid", a_win_valid, 1);
            chk("hold_out_col", a_out_col, 0);
            chk("hold_rd_en", a_rd_en, 0);
        end
        a_cycle(1'b0, 1'b0, 1'b1);
        chk("release_rd_en", a_rd_en, 1);
        chk("release_rd_addr", a_rd_addr, 1);
        for (int i = 0; i < 4; i++) begin
            a_cycle(1'b0, 1'b0, 1'b1);
            chk("b2b_rd_en", a_rd_en, 1);
            chk("b2b_win_valid", a_win_valid, 1);
        end
        a_finish("hold");

        // Stride 2 on the 7x7 plane
        b_cycle(1'b1, 1'b1, 1'b1);
        n = 0;
        while (b_plane && n < 300) begin
            b_cycle(1'b0, b_pix < B_NPIX, 1'b1);
            n++;
        end
        chk("b_done_seen", b_plane, 0);
        chk("b_last_rd_seen", b_last_seen, 1);
        chk("b_reads_left", b_addr_q.size(), 0);
        chk("b_busy_after", b_busy, 0);

        // start while busy is ignored
        a_cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) a_cycle(1'b0, 1'b1, 1'b1);
        a_cycle(1'b1, 1'b1, 1'b1);
        chk("restart_busy", a_busy, 1);
        a_finish("restart_ignored");

        // Overflow on the 21st write
        a_cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) a_cycle(1'b0, 1'b1, 1'b0);
        a_cycle(1'b0, 1'b1, 1'b0);
        chk("ovf_before_21st", a_ovf, 0);
        a_cycle(1'b0, 1'b0, 1'b0);
        chk("ovf_after_21st", a_ovf, 1);
        a_finish("ovf_plane");
        a_cycle(1'b1, 1'b0, 1'b1);
        a_cycle(1'b0, 1'b0, 1'b1);
        chk("ovf_sticky_start", a_ovf, 1);
        chk("ovf_plane_busy", a_busy, 1);

        // Asynchronous reset after three windows
        n = 0;
        while (a_crd_q.size() > 3 && n < 100) begin
            a_cycle(1'b0, a_pix < A_NPIX, 1'b1);
            n++;
        end
        chk("pre_rst_wins_taken", a_crd_q.size(), 3);
        a_rst_a = 1'b0;
        #1;
        chk("arst_rd_en", a_rd_en, 0);
        chk("arst_rd_addr", a_rd_addr, 0);
        chk("arst_win_valid", a_win_valid, 0);
        chk("arst_out_row", a_out_row, 0);
        chk("arst_out_col", a_out_col, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_done", a_done, 0);
        chk("arst_ovf", a_ovf, 0);
        a_addr_q.delete();
        a_crd_q.delete();
        a_plane = 1'b0;
        a_pix   = 0;
        for (int i = 0; i < 3; i++) begin
            a_cycle(1'b0, 1'b0, 1'b1);
            chk("arst_no_done", a_done, 0);
        end
        a_rst_a = 1'b1;
        a_cycle(1'b0, 1'b0, 1'b1);
        chk("post_rst_idle_done", a_done, 0);
        chk("post_rst_idle_busy", a_busy, 0);
        a_cycle(1'b1, 1'b1, 1'b1);
        a_finish("post_reset");
        chk("post_reset_ovf", a_ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
